// File: rtl/bemicro_cv_nios_cpu_ocimem_pkg.sv
// Shared types and defaults for the OCI RAM arbiter slice.
// Holds the sequencer state encoding, the grant-owner encoding and the
// default address/data widths used by the arbiter and its picker.
package bemicro_cv_nios_cpu_ocimem_pkg;

    localparam int OCIMEM_ADDR_W = 8;
    localparam int OCIMEM_DATA_W = 32;

    // IDLE: arbitration allowed. RD_DATA: RAM read data valid, no new grant.
    typedef enum logic {
        IDLE    = 1'b0,
        RD_DATA = 1'b1
    } ocimem_state_e;

    // Requester identity; also the encoding of the round-robin history bit.
    typedef enum logic {
        GRANT_CPU  = 1'b0,
        GRANT_JTAG = 1'b1
    } ocimem_owner_e;

endpackage

// File: rtl/bemicro_cv_nios_cpu_ocimem_rr_pick.sv
// Two-way round-robin picker between the CPU debug slave and the JTAG
// request latch. A tie goes to the requester that did not win last time;
// the history bit resets to GRANT_CPU so JTAG wins the first tie.
module bemicro_cv_nios_cpu_ocimem_rr_pick
    import bemicro_cv_nios_cpu_ocimem_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_en,
    input  logic          i_req_cpu,
    input  logic          i_req_jtag,
    output logic          o_gnt,
    output ocimem_owner_e o_owner
);

    ocimem_owner_e r_last_grant;

    // Choose the winner for this cycle from the requests and the history bit.
    always_comb begin
        o_gnt   = i_en & (i_req_cpu | i_req_jtag);
        o_owner = GRANT_CPU;
        if (i_req_cpu && i_req_jtag) begin
            o_owner = (r_last_grant == GRANT_CPU) ? GRANT_JTAG : GRANT_CPU;
        end else if (i_req_jtag) begin
            o_owner = GRANT_JTAG;
        end
    end

    // Remember the owner of every grant actually issued.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= GRANT_CPU;
        end else if (o_gnt) begin
            r_last_grant <= o_owner;
        end
    end

endmodule

// File: rtl/bemicro_cv_nios_cpu_ocimem_arbiter.sv
// Sysclk-domain arbiter/sequencer for the Nios II OCI debug RAM.
// Shares a single-port, 1-cycle-latency RAM between the JTAG command path
// (one-deep request latch, MonDReg return) and the CPU Avalon debug slave.
// Handshake: the CPU holds avs_read/avs_write until a cycle with
// avs_waitrequest=0; that cycle completes the transfer (writes in the grant
// cycle, reads one cycle later with avs_readdata valid).
// Build option: define OCIMEM_AUTOINC_EN to post-increment the JTAG address
// after every completed JTAG access (jtag_set_addr takes priority).
module bemicro_cv_nios_cpu_ocimem_arbiter
    import bemicro_cv_nios_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = OCIMEM_ADDR_W,
    parameter int DATA_W = OCIMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_set_addr,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic              jtag_access,
    input  logic              jtag_wr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic [DATA_W-1:0] mon_dreg,
    output logic              mon_ready,
    output logic              mon_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              dbg_state
);

    ocimem_state_e     r_state;
    ocimem_owner_e     r_owner;
    logic [ADDR_W-1:0] r_jaddr;
    logic              r_jpend;
    logic              r_jwr;
    logic [DATA_W-1:0] r_jwdata;
    logic [DATA_W-1:0] r_mon_dreg;
    logic              r_mon_ready;
    logic              r_mon_error;

    logic              w_idle;
    logic              w_rd_data;
    logic              w_cpu_req;
    logic              w_gnt;
    ocimem_owner_e     w_gnt_owner;
    logic              w_gnt_cpu;
    logic              w_gnt_jtag;
    logic              w_gnt_wr;
    logic              w_jtag_done;
    logic              w_cpu_done;

    assign w_idle     = (r_state == IDLE) & ~reset;
    assign w_rd_data  = (r_state == RD_DATA) & ~reset;
    assign w_cpu_req  = avs_read | avs_write;

    bemicro_cv_nios_cpu_ocimem_rr_pick u_rr_pick (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_en       (w_idle),
        .i_req_cpu  (w_cpu_req),
        .i_req_jtag (r_jpend),
        .o_gnt      (w_gnt),
        .o_owner    (w_gnt_owner)
    );

    assign w_gnt_cpu  = w_gnt & (w_gnt_owner == GRANT_CPU);
    assign w_gnt_jtag = w_gnt & (w_gnt_owner == GRANT_JTAG);
    // A CPU request with both strobes high is treated as a write.
    assign w_gnt_wr   = w_gnt_jtag ? r_jwr : (w_gnt_cpu & avs_write);

    // Completion: writes finish in the grant cycle, reads in RD_DATA.
    assign w_jtag_done = (w_gnt_jtag & r_jwr) | (w_rd_data & (r_owner == GRANT_JTAG));
    assign w_cpu_done  = (w_gnt_cpu & avs_write) | (w_rd_data & (r_owner == GRANT_CPU));

    // RAM port and CPU response are steered combinationally from the grant.
    always_comb begin
        ram_addr  = r_jaddr;
        ram_wdata = '0;
        if (w_gnt_cpu) begin
            ram_addr  = avs_address;
            ram_wdata = avs_writedata;
        end else if (w_gnt_jtag) begin
            ram_wdata = r_jwdata;
        end
    end

    assign ram_wren        = w_gnt & w_gnt_wr;
    assign avs_waitrequest = w_cpu_req & ~w_cpu_done;
    assign avs_readdata    = ram_rdata;
    assign mon_dreg        = r_mon_dreg;
    assign mon_ready       = r_mon_ready;
    assign mon_error       = r_mon_error;
    assign dbg_state       = r_state;

    // Sequencer: a read grant spends one cycle in RD_DATA waiting for RAM data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= GRANT_CPU;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt && !w_gnt_wr) begin
                        r_state <= RD_DATA;
                        r_owner <= w_gnt_owner;
                    end
                end
                RD_DATA: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // One-deep JTAG request latch with ready/overrun status and MonDReg capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_jpend     <= 1'b0;
            r_jwr       <= 1'b0;
            r_jwdata    <= '0;
            r_mon_dreg  <= '0;
            r_mon_ready <= 1'b1;
            r_mon_error <= 1'b0;
        end else begin
            if (w_jtag_done) begin
                r_jpend     <= 1'b0;
                r_mon_ready <= 1'b1;
            end
            if (w_rd_data && (r_owner == GRANT_JTAG)) begin
                r_mon_dreg <= ram_rdata;
            end
            if (jtag_set_addr) begin
                r_mon_error <= 1'b0;
            end
            // An access arriving while one is still pending is an overrun.
            if (jtag_access) begin
                if (!r_jpend) begin
                    r_jpend     <= 1'b1;
                    r_jwr       <= jtag_wr;
                    r_jwdata    <= jtag_wdata;
                    r_mon_ready <= 1'b0;
                end else begin
                    r_mon_error <= 1'b1;
                end
            end
        end
    end

    // JTAG address register; a grant this cycle already used the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_jaddr <= '0;
        end else begin
`ifdef OCIMEM_AUTOINC_EN
            if (w_jtag_done) begin
                r_jaddr <= r_jaddr + ADDR_W'(1);
            end
`endif
            if (jtag_set_addr) begin
                r_jaddr <= jtag_addr;
            end
        end
    end

endmodule

// File: tb/tb_bemicro_cv_nios_cpu_ocimem_arbiter.sv
// Self-checking bench for the OCI RAM arbiter. A golden memory plus a JTAG
// operation queue forms the transaction-level model; directed sequences add
// literal cycle-exact expectations.
module tb_bemicro_cv_nios_cpu_ocimem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          jtag_set_addr = 1'b0;
  logic [AW-1:0] jtag_addr = '0;
  logic          jtag_access = 1'b0;
  logic          jtag_wr = 1'b0;
  logic [DW-1:0] jtag_wdata = '0;
  logic [DW-1:0] mon_dreg;
  logic          mon_ready;
  logic          mon_error;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [DW-1:0] avs_writedata = '0;
  logic [DW-1:0] avs_readdata;
  logic          avs_waitrequest;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          dbg_state;

  bemicro_cv_nios_cpu_ocimem_arbiter dut (
    .clk(clk), .reset(reset),
    .jtag_set_addr(jtag_set_addr), .jtag_addr(jtag_addr),
    .jtag_access(jtag_access), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
    .mon_dreg(mon_dreg), .mon_ready(mon_ready), .mon_error(mon_error),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- OCI RAM (single port, 1-cycle read) ----------------
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- model state ----------------
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } jop_t;

  logic [DW-1:0] gold [256];
  jop_t          exp_q [$];
  logic [AW-1:0] m_jaddr = '0;
  logic          prev_ready = 1'b1;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    jop_t op;
    if (reset) begin
      chk("rst_wren", {31'd0, ram_wren}, 32'd0);
      chk("rst_waitreq", {31'd0, avs_waitrequest}, {31'd0, avs_read | avs_write});
    end else begin
      // JTAG completion is visible as mon_ready returning high.
      if (mon_ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL jtag_unexpected_done: got completion expected none at %0t", $time);
        end else begin
          op = exp_q.pop_front();
          if (op.wr) gold[op.a] = op.d;
          else chk("jtag_rdata", mon_dreg, gold[op.a]);
        end
      end
      if ((avs_read || avs_write) && !avs_waitrequest) begin
        if (avs_write) gold[avs_address] = avs_writedata;
        else chk("cpu_rdata", avs_readdata, gold[avs_address]);
      end
    end
    prev_ready = mon_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    m_jaddr = '0;
    exp_q.delete();
  endtask

  task automatic jtag_set(input logic [AW-1:0] a);
    @(posedge clk); #1;
    jtag_set_addr = 1'b1;
    jtag_addr = a;
    m_jaddr = a;
    @(posedge clk); #1;
    jtag_set_addr = 1'b0;
  endtask

  task automatic push_jop(input logic wr, input logic [DW-1:0] d);
    exp_q.push_back('{wr: wr, a: m_jaddr, d: d});
`ifdef OCIMEM_AUTOINC_EN
    m_jaddr = m_jaddr + 8'd1;
`endif
  endtask

  task automatic jtag_op(input logic wr, input logic [DW-1:0] d);
    bit done;
    @(posedge clk); #1;
    jtag_access = 1'b1;
    jtag_wr = wr;
    jtag_wdata = d;
    push_jop(wr, d);
    @(posedge clk); #1;
    jtag_access = 1'b0;
    done = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mon_ready) begin done = 1; break; end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL jtag_timeout: got mon_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic cpu_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd);
    bit done;
    @(posedge clk); #1;
    avs_address = a;
    avs_write = wr;
    avs_read = ~wr;
    avs_writedata = d;
    done = 0;
    rd = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin done = 1; rd = avs_readdata; break; end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL cpu_timeout: got waitrequest=1 expected 0 within 20 cycles");
    end
    @(posedge clk); #1;
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_fe, exp_ff, exp_00, exp_01;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'hA500_0000 | i;
      gold[i] = 32'hA500_0000 | i;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state held while idle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, mon_ready}, 32'd1);
      chk("idle_error", {31'd0, mon_error}, 32'd0);
      chk("idle_dreg", mon_dreg, 32'd0);
      chk("idle_wren", {31'd0, ram_wren}, 32'd0);
    end

    // JTAG write to 0x10, then CPU read back.
    jtag_set(8'h10);
    @(posedge clk); #1;
    jtag_access = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'hDEAD_BEEF;
    push_jop(1'b1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    jtag_access = 1'b0;
    @(negedge clk);
    chk("jw_g_wren", {31'd0, ram_wren}, 32'd1);
    chk("jw_g_addr", {24'd0, ram_addr}, 32'h10);
    chk("jw_g_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("jw_g_ready", {31'd0, mon_ready}, 32'd0);
    @(negedge clk);
    chk("jw_g1_ready", {31'd0, mon_ready}, 32'd1);
    chk("jw_g1_wren", {31'd0, ram_wren}, 32'd0);
    @(posedge clk); #1;
    avs_read = 1'b1; avs_address = 8'h10;
    @(negedge clk);
    chk("cr_g_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    @(negedge clk);
    chk("cr_g1_waitreq", {31'd0, avs_waitrequest}, 32'd0);
    chk("cr_g1_rdata", avs_readdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    avs_read = 1'b0;

    // Tie after reset: JTAG read first, then CPU write after RD_DATA.
    do_reset();
    jtag_access = 1'b1; jtag_wr = 1'b0;
    push_jop(1'b0, 32'd0);
    @(posedge clk); #1;
    jtag_access = 1'b0;
    avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h1234_5678;
    @(negedge clk);
    chk("tie_g_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    chk("tie_g_wren", {31'd0, ram_wren}, 32'd0);
    chk("tie_g_addr", {24'd0, ram_addr}, 32'h00);
    @(negedge clk);
    chk("tie_rd_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    @(negedge clk);
    chk("tie_cw_waitreq", {31'd0, avs_waitrequest}, 32'd0);
    chk("tie_cw_wren", {31'd0, ram_wren}, 32'd1);
    chk("tie_cw_addr", {24'd0, ram_addr}, 32'h20);
    chk("tie_mon_ready", {31'd0, mon_ready}, 32'd1);
    chk("tie_mon_dreg", mon_dreg, 32'hA500_0000);
    @(posedge clk); #1;
    avs_write = 1'b0;

    // Overrun: second access while pending is dropped and flags an error.
    jtag_set(8'h30);
    @(posedge clk); #1;
    jtag_access = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h1111_1111;
    push_jop(1'b1, 32'h1111_1111);
    @(posedge clk); #1;
    jtag_wdata = 32'h2222_2222;
    @(negedge clk);
    chk("ovr_g_wdata", ram_wdata, 32'h1111_1111);
    chk("ovr_g_ready", {31'd0, mon_ready}, 32'd0);
    @(posedge clk); #1;
    jtag_access = 1'b0;
    @(negedge clk);
    chk("ovr_error", {31'd0, mon_error}, 32'd1);
    chk("ovr_ready", {31'd0, mon_ready}, 32'd1);
    repeat (2) @(negedge clk);
    chk("ovr_error_sticky", {31'd0, mon_error}, 32'd1);
    jtag_set(8'h30);
    @(negedge clk);
    chk("ovr_error_clr", {31'd0, mon_error}, 32'd0);
    jtag_op(1'b0, 32'd0);
    chk("ovr_first_kept", mon_dreg, 32'h1111_1111);

    // Interleaved CPU writes and JTAG reads of the same words.
    for (int i = 0; i < 4; i++) begin
      cpu_xfer(1'b1, 8'h40 + 8'(i), 32'hC0DE_0000 + i, rd);
      jtag_set(8'h40 + 8'(i));
      jtag_op(1'b0, 32'd0);
      chk("mix_jtag_rd", mon_dreg, 32'hC0DE_0000 + i);
      cpu_xfer(1'b0, 8'h40 + 8'(i), 32'd0, rd);
      chk("mix_cpu_rd", rd, 32'hC0DE_0000 + i);
    end

    // JTAG write burst starting at 0xFE.
    jtag_set(8'hFE);
    for (int i = 1; i <= 4; i++) jtag_op(1'b1, i);
`ifdef OCIMEM_AUTOINC_EN
    exp_fe = 32'd1; exp_ff = 32'd2; exp_00 = 32'd3; exp_01 = 32'd4;
`else
    exp_fe = 32'd4; exp_ff = 32'hA500_00FF; exp_00 = 32'hA500_0000; exp_01 = 32'hA500_0001;
`endif
    cpu_xfer(1'b0, 8'hFE, 32'd0, rd); chk("burst_fe", rd, exp_fe);
    cpu_xfer(1'b0, 8'hFF, 32'd0, rd); chk("burst_ff", rd, exp_ff);
    cpu_xfer(1'b0, 8'h00, 32'd0, rd); chk("burst_00", rd, exp_00);
    cpu_xfer(1'b0, 8'h01, 32'd0, rd); chk("burst_01", rd, exp_01);

    // Reset during RD_DATA of a CPU read: dropped, then re-granted.
    @(posedge clk); #1;
    avs_read = 1'b1; avs_address = 8'h10;
    @(negedge clk);
    chk("rr_g_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rr_rst1_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_rst2_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    m_jaddr = '0;
    @(negedge clk);
    chk("rr_regrant_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    @(negedge clk);
    chk("rr_done_waitreq", {31'd0, avs_waitrequest}, 32'd0);
    chk("rr_done_rdata", avs_readdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    avs_read = 1'b0;

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL jtag_queue_left: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bemicro_cv_nios_cpu_ocimem_arbiter.md
Name: bemicro_cv_nios_cpu_ocimem_arbiter

Overview:
Sysclk-domain arbiter and sequencer for the Nios II on-chip debug RAM (OCI RAM, single-port, 1-cycle read latency). Two requesters share it:
- the JTAG command path: address-set and access pulses decoded from jdo by the debug module's sysclk logic;
- the CPU's Avalon-MM debug slave.
Read data for JTAG is returned through the MonDReg holding register with monitor_ready and monitor_error status.

Parameters:
ADDR_W, 8, OCI RAM word-address width
DATA_W, 32, data width (MonDReg width)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jtag_set_addr  in  1  one-cycle pulse: load JTAG address register from jtag_addr
jtag_addr  in  ADDR_W  address for jtag_set_addr
jtag_access  in  1  one-cycle pulse: request one JTAG access at the JTAG address register
jtag_wr  in  1  with jtag_access: 1=write, 0=read
jtag_wdata  in  DATA_W  write data, sampled with jtag_access
mon_dreg  out  DATA_W  MonDReg: last JTAG read data
mon_ready  out  1  JTAG side idle, no pending access
mon_error  out  1  sticky overrun error
avs_address  in  ADDR_W  CPU debug-slave address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  DATA_W  CPU write data
avs_readdata  out  DATA_W  CPU read data, valid when avs_read=1 and avs_waitrequest=0
avs_waitrequest  out  1  Avalon waitrequest
ram_addr  out  ADDR_W  OCI RAM address
ram_wren  out  1  OCI RAM write enable
ram_wdata  out  DATA_W  OCI RAM write data
ram_rdata  in  DATA_W  OCI RAM read data, valid 1 cycle after address

Behaviour:
- FSM states: IDLE, RD_DATA. Registers:
  - jaddr (JTAG address)
  - jpend, jwr, jwdata (one-deep JTAG request latch)
  - owner (requester of the read in flight)
  - last_grant (0=CPU, 1=JTAG)
- Reset values:
  - state=IDLE, jpend=0, jaddr=0, last_grant=0 (JTAG wins the first tie)
  - mon_dreg=0, mon_ready=1, mon_error=0
- Outputs during reset:
  - ram_wren=0
  - avs_waitrequest=1 whenever avs_read|avs_write is asserted
- Reset mid-read: the read is dropped and no data is delivered.
- JTAG request capture (every cycle):
  - jtag_access with jpend=0: set jpend and capture jwr/jwdata; mon_ready=0 from the next cycle.
  - jtag_access with jpend=1: request discarded; mon_error=1.
  - jtag_set_addr: loads jaddr and clears mon_error. It has no effect on an already-pending access's address if the grant happens the same cycle, because the grant uses the old jaddr.
- Arbitration, evaluated only in IDLE:
  - Candidates are jpend and (avs_read|avs_write).
  - If both are present, grant the requester that is not last_grant. Update last_grant on every grant.
- Grant cycle G:
  - ram_addr = jaddr or avs_address; ram_wdata = jwdata or avs_writedata (combinational from the IDLE decision).
  - Write: ram_wren=1 in G; the access completes in G. CPU sees avs_waitrequest=0 in G. JTAG: jpend clears, mon_ready=1 at G+1.
  - Read: ram_wren=0; go to RD_DATA for G+1. In RD_DATA, ram_rdata is valid and no new grant is made.
    - CPU owner: avs_readdata=ram_rdata, avs_waitrequest=0 in G+1.
    - JTAG owner: mon_dreg<=ram_rdata at the end of G+1; jpend clears; mon_ready=1 at G+2.
  - Then return to IDLE.
- Throughput: a write occupies 1 cycle, a read 2. A new grant is possible in the cycle after a write or RD_DATA.
- avs_waitrequest = (avs_read|avs_write) & ~cpu_done, where cpu_done is combinational.
- avs_read and avs_write both asserted: treated as a write.
- ram_wren is never asserted outside a write grant.
- When idle: ram_addr holds jaddr and ram_wdata=0.

Optional Feature:
OCIMEM_AUTOINC_EN:
- Defined: jaddr increments by 1 (wraps modulo 2^ADDR_W) on completion of each JTAG access. Completion is G for a write and G+1 for a read. If jtag_set_addr arrives in the same cycle, jtag_set_addr wins.
- Undefined: jaddr changes only on jtag_set_addr.

Decomposition:
- Package bemicro_cv_nios_cpu_ocimem_pkg holds: the state enum (IDLE, RD_DATA), the grant-owner encoding (GRANT_CPU=0, GRANT_JTAG=1), and default ADDR_W/DATA_W.
- One sub-module, bemicro_cv_nios_cpu_ocimem_rr_pick: a 2-way round-robin picker with last_grant state.
- All other logic stays in the top module.

Test Plan:
- Reset then idle -> mon_ready=1, mon_error=0, mon_dreg=0, ram_wren=0 for 10 cycles.
- jtag_set_addr(0x10); jtag_access wr, wdata=0xDEADBEEF; then CPU read 0x10 -> ram_wren at G, mon_ready back at G+1; avs_readdata=0xDEADBEEF with waitrequest=0 exactly one cycle after the CPU grant.
- JTAG read pending and CPU write asserted in the same IDLE cycle after reset -> JTAG read granted first (last_grant=0). CPU write is granted in the cycle after RD_DATA, with waitrequest low in that cycle only.
- Second jtag_access while jpend=1 -> mon_error=1, first access completes normally; next jtag_set_addr clears mon_error.
- OCIMEM_AUTOINC_EN: set_addr 0xFE, four JTAG writes 1,2,3,4 -> RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3, RAM[0x01]=4 (wrap).
- Reset asserted during RD_DATA of a CPU read -> no readdata delivered, waitrequest stays 1. After reset the CPU read is re-granted and completes with the correct data.
